// File: rtl/dsp48a1_slice.sv
`default_nettype none
// ============================================================================
// Module      : dsp48a1_slice
// Description : Multiply-accumulate slice after the Spartan-6 DSP48A1.
//               18-bit pre-adder/subtracter -> 18x18 unsigned multiplier ->
//               48-bit post-adder/subtracter with optional pipeline registers.
//               OPMODE selects the X/Z operands, the carry-in and add/sub.
//
// Ports       : clk, rst_n (async, active low)
//               A, B, Bcin, D (18) ; C, PCIN (48) ; carryIn ; OPMODE (8)
//               RSTA/B/C/D/M/P/CarryIn, RST_OPMODE : sync clears per group
//               CEA/B/C/D/M/P/CarryIn, CE_OPMODE   : clock enables per group
//               Bcout (18), M (36), P (48), Pcout (48), CarryOut, CarryOutF
//
// Options     : macro DSP_BCIN_SEL_EN - when defined, B_INPUT = "CASCADE"
//               feeds Bcin into the B0 stage; otherwise B0 always takes B.
//
// Revision    : 1.0 - initial release
// ============================================================================
module dsp48a1_slice #(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] Bcin,
    input  logic [17:0] D,
    input  logic [47:0] C,
    input  logic [47:0] PCIN,
    input  logic        carryIn,
    input  logic [7:0]  OPMODE,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTC,
    input  logic        RSTD,
    input  logic        RSTM,
    input  logic        RSTP,
    input  logic        RSTCarryIn,
    input  logic        RST_OPMODE,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEC,
    input  logic        CED,
    input  logic        CEM,
    input  logic        CEP,
    input  logic        CECarryIn,
    input  logic        CE_OPMODE,
    output logic [17:0] Bcout,
    output logic [35:0] M,
    output logic [47:0] P,
    output logic [47:0] Pcout,
    output logic        CarryOut,
    output logic        CarryOutF
);

    localparam bit c_cin_from_opmode = (CARRYINSEL == "OPMODE5");
    localparam bit c_b_cascade       = (B_INPUT == "CASCADE");

    logic [17:0] w_a0;
    logic [17:0] w_a1;
    logic [17:0] w_b0_in;
    logic [17:0] w_b0;
    logic [17:0] w_b1_in;
    logic [17:0] w_b1;
    logic [17:0] w_d;
    logic [17:0] w_preadd;
    logic [47:0] w_c;
    logic [7:0]  w_opmode;
    logic [35:0] w_m_in;
    logic [35:0] w_m;
    logic [47:0] w_x;
    logic [47:0] w_z;
    logic        w_cin;
    logic        w_cyi;
    logic [48:0] w_post;
    logic [47:0] w_p;
    logic        w_cyo;

    // ------------------------------------------------------------------------
    // B0 source selection
    // ------------------------------------------------------------------------
`ifdef DSP_BCIN_SEL_EN
    assign w_b0_in = c_b_cascade ? Bcin : B;
`else
    // Cascade input is not wired into the datapath in this build.
    logic w_unused_bcin;
    assign w_unused_bcin = ^{Bcin, c_b_cascade};
    assign w_b0_in       = B;
`endif

    // ------------------------------------------------------------------------
    // Input stage registers: each is a flop only when its parameter is 1.
    // Priority: async rst_n > sync RSTx > CEx load > hold.
    // ------------------------------------------------------------------------
    generate
        if (A0REG == 1) begin : g_a0_reg
            logic [17:0] r_a0;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    r_a0 <= '0;
                else if (RSTA) r_a0 <= '0;
                else if (CEA)  r_a0 <= A;
            end
            assign w_a0 = r_a0;
        end else begin : g_a0_wire
            assign w_a0 = A;
        end

        if (A1REG == 1) begin : g_a1_reg
            logic [17:0] r_a1;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    r_a1 <= '0;
                else if (RSTA) r_a1 <= '0;
                else if (CEA)  r_a1 <= w_a0;
            end
            assign w_a1 = r_a1;
        end else begin : g_a1_wire
            assign w_a1 = w_a0;
        end

        if (B0REG == 1) begin : g_b0_reg
            logic [17:0] r_b0;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    r_b0 <= '0;
                else if (RSTB) r_b0 <= '0;
                else if (CEB)  r_b0 <= w_b0_in;
            end
            assign w_b0 = r_b0;
        end else begin : g_b0_wire
            assign w_b0 = w_b0_in;
        end

        if (B1REG == 1) begin : g_b1_reg
            logic [17:0] r_b1;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    r_b1 <= '0;
                else if (RSTB) r_b1 <= '0;
                else if (CEB)  r_b1 <= w_b1_in;
            end
            assign w_b1 = r_b1;
        end else begin : g_b1_wire
            assign w_b1 = w_b1_in;
        end

        if (CREG == 1) begin : g_c_reg
            logic [47:0] r_c;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    r_c <= '0;
                else if (RSTC) r_c <= '0;
                else if (CEC)  r_c <= C;
            end
            assign w_c = r_c;
        end else begin : g_c_wire
            assign w_c = C;
        end

        if (DREG == 1) begin : g_d_reg
            logic [17:0] r_d;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    r_d <= '0;
                else if (RSTD) r_d <= '0;
                else if (CED)  r_d <= D;
            end
            assign w_d = r_d;
        end else begin : g_d_wire
            assign w_d = D;
        end

        if (OPMODEREG == 1) begin : g_opmode_reg
            logic [7:0] r_opmode;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)          r_opmode <= '0;
                else if (RST_OPMODE) r_opmode <= '0;
                else if (CE_OPMODE)  r_opmode <= OPMODE;
            end
            assign w_opmode = r_opmode;
        end else begin : g_opmode_wire
            assign w_opmode = OPMODE;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Pre-adder (wraps modulo 2^18) and B1 source
    // ------------------------------------------------------------------------
    assign w_preadd = w_opmode[6] ? (w_d - w_b0) : (w_d + w_b0);
    assign w_b1_in  = w_opmode[4] ? w_preadd : w_b0;

    // ------------------------------------------------------------------------
    // Multiplier and M stage
    // ------------------------------------------------------------------------
    assign w_m_in = {18'b0, w_a1} * {18'b0, w_b1};

    generate
        if (MREG == 1) begin : g_m_reg
            logic [35:0] r_m;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    r_m <= '0;
                else if (RSTM) r_m <= '0;
                else if (CEM)  r_m <= w_m_in;
            end
            assign w_m = r_m;
        end else begin : g_m_wire
            assign w_m = w_m_in;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Post-adder operand muxes and carry-in
    // ------------------------------------------------------------------------
    always_comb begin
        w_x = '0;
        case (w_opmode[1:0])
            2'd0:    w_x = '0;
            2'd1:    w_x = {12'b0, w_m};
            2'd2:    w_x = w_p;
            default: w_x = {w_d[11:0], w_a1, w_b1};
        endcase
    end

    always_comb begin
        w_z = '0;
        case (w_opmode[3:2])
            2'd0:    w_z = '0;
            2'd1:    w_z = PCIN;
            2'd2:    w_z = w_p;
            default: w_z = w_c;
        endcase
    end

    assign w_cin = c_cin_from_opmode ? w_opmode[5] : carryIn;

    generate
        if (CARRYINREG == 1) begin : g_cyi_reg
            logic r_cyi;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)          r_cyi <= 1'b0;
                else if (RSTCarryIn) r_cyi <= 1'b0;
                else if (CECarryIn)  r_cyi <= w_cin;
            end
            assign w_cyi = r_cyi;
        end else begin : g_cyi_wire
            assign w_cyi = w_cin;
        end
    endgenerate

    // 49-bit post-adder: bit 48 is the carry for addition and the borrow
    // (result negative) for subtraction.
    assign w_post = w_opmode[7]
                  ? ({1'b0, w_z} - ({1'b0, w_x} + {48'b0, w_cyi}))
                  : ({1'b0, w_z} + {1'b0, w_x} + {48'b0, w_cyi});

    // ------------------------------------------------------------------------
    // Output stage. With PREG = 0 and X or Z selecting P the feedback path
    // becomes a combinational loop, so feedback OPMODEs need PREG = 1.
    // ------------------------------------------------------------------------
    generate
        if (PREG == 1) begin : g_p_reg
            logic [47:0] r_p;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    r_p <= '0;
                else if (RSTP) r_p <= '0;
                else if (CEP)  r_p <= w_post[47:0];
            end
            assign w_p = r_p;
        end else begin : g_p_wire
            assign w_p = w_post[47:0];
        end

        // The carry-out flop shares the carry-in clear/enable group.
        if (CARRYOUTREG == 1) begin : g_cyo_reg
            logic r_cyo;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)          r_cyo <= 1'b0;
                else if (RSTCarryIn) r_cyo <= 1'b0;
                else if (CECarryIn)  r_cyo <= w_post[48];
            end
            assign w_cyo = r_cyo;
        end else begin : g_cyo_wire
            assign w_cyo = w_post[48];
        end
    endgenerate

    assign Bcout     = w_b1;
    assign M         = w_m;
    assign P         = w_p;
    assign Pcout     = w_p;
    assign CarryOut  = w_cyo;
    assign CarryOutF = w_cyo;

endmodule
`default_nettype wire

// File: tb/tb_dsp48a1_slice.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp48a1_slice
// Description : Self-checking bench for dsp48a1_slice (default parameters,
//               DSP_BCIN_SEL_EN undefined). A history-based latency model
//               predicts every registered output from the applied inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp48a1_slice;

    localparam longint c_mask48 = 64'h0000_FFFF_FFFF_FFFF;
    localparam longint c_two48  = 64'h0001_0000_0000_0000;
    localparam int     c_depth  = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] A, B, Bcin, D;
    logic [47:0] C, PCIN;
    logic        carryIn;
    logic [7:0]  OPMODE;
    logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCarryIn, RST_OPMODE;
    logic        CEA, CEB, CEC, CED, CEM, CEP, CECarryIn, CE_OPMODE;
    logic [17:0] Bcout;
    logic [35:0] M;
    logic [47:0] P, Pcout;
    logic        CarryOut, CarryOutF;

    int checks = 0;
    int errors = 0;

    dsp48a1_slice dut (
        .clk(clk), .rst_n(rst_n),
        .A(A), .B(B), .Bcin(Bcin), .D(D), .C(C), .PCIN(PCIN),
        .carryIn(carryIn), .OPMODE(OPMODE),
        .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD),
        .RSTM(RSTM), .RSTP(RSTP), .RSTCarryIn(RSTCarryIn), .RST_OPMODE(RST_OPMODE),
        .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED),
        .CEM(CEM), .CEP(CEP), .CECarryIn(CECarryIn), .CE_OPMODE(CE_OPMODE),
        .Bcout(Bcout), .M(M), .P(P), .Pcout(Pcout),
        .CarryOut(CarryOut), .CarryOutF(CarryOutF)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: index k = value applied at / visible after edge k.
    // Index 0 describes the all-zero state right after reset.
    // ------------------------------------------------------------------------
    longint ha[0:c_depth-1], hb[0:c_depth-1], hd[0:c_depth-1], hc[0:c_depth-1];
    longint hpcin[0:c_depth-1], hop[0:c_depth-1];
    longint hrstp[0:c_depth-1], hcep[0:c_depth-1];
    longint eb1[0:c_depth-1], em[0:c_depth-1], ep[0:c_depth-1], ecyo[0:c_depth-1];
    int     n = 0;

    function automatic void model_clear();
        n = 0;
        ha[0] = 0; hb[0] = 0; hd[0] = 0; hc[0] = 0; hpcin[0] = 0; hop[0] = 0;
        hrstp[0] = 0; hcep[0] = 1;
        eb1[0] = 0; em[0] = 0; ep[0] = 0; ecyo[0] = 0;
    endfunction

    // Latencies: OPMODE/D/C/A are seen one edge late, B0 is a wire,
    // the carry-in is seen two edges after OPMODE is applied.
    function automatic void model_eval(int k);
        longint opu, dreg, pre, x, z, cin, s;
        opu  = hop[k-1];
        dreg = hd[k-1];
        pre  = ((opu >> 6) & 1) != 0 ? (dreg - hb[k]) : (dreg + hb[k]);
        pre  = pre & 64'h3FFFF;
        eb1[k] = ((opu >> 4) & 1) != 0 ? pre : hb[k];
        em[k]  = ha[k-1] * eb1[k-1];
        case (opu & 3)
            0:       x = 0;
            1:       x = em[k-1];
            2:       x = ep[k-1];
            default: x = ((dreg & 64'hFFF) << 36) | (ha[k-1] << 18) | eb1[k-1];
        endcase
        case ((opu >> 2) & 3)
            0:       z = 0;
            1:       z = hpcin[k];
            2:       z = ep[k-1];
            default: z = hc[k-1];
        endcase
        cin = (k >= 2) ? ((hop[k-2] >> 5) & 1) : 0;
        if (((opu >> 7) & 1) != 0) begin
            s = z - (x + cin);
            ecyo[k] = (s < 0) ? 1 : 0;
        end else begin
            s = z + x + cin;
            ecyo[k] = (s >= c_two48) ? 1 : 0;
        end
        if (hrstp[k] != 0)     ep[k] = 0;
        else if (hcep[k] != 0) ep[k] = s & c_mask48;
        else                   ep[k] = ep[k-1];
    endfunction

    // Apply current inputs for one clock and advance the model.
    task automatic step();
        n++;
        ha[n] = longint'(A); hb[n] = longint'(B); hd[n] = longint'(D);
        hc[n] = longint'(C); hpcin[n] = longint'(PCIN); hop[n] = longint'(OPMODE);
        hrstp[n] = longint'(RSTP); hcep[n] = longint'(CEP);
        model_eval(n);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        A = 18'h3FFFF; B = 18'h2AAAA; D = 18'h15555; Bcin = 18'h12345;
        C = 48'hFFFF_0000_FFFF; PCIN = 48'h1234_5678_9ABC; OPMODE = 8'hFF; carryIn = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (P !== 48'd0)     begin errors++; $display("FAIL reset_P got %h want 0", P); end
        checks++; if (M !== 36'd0)     begin errors++; $display("FAIL reset_M got %h want 0", M); end
        checks++; if (Bcout !== 18'd0) begin errors++; $display("FAIL reset_Bcout got %h want 0", Bcout); end
        checks++; if (CarryOut !== 1'b0) begin errors++; $display("FAIL reset_CarryOut got %b want 0", CarryOut); end
        checks++; if (Pcout !== 48'd0 || CarryOutF !== 1'b0)
            begin errors++; $display("FAIL reset_cascade got Pcout=%h CarryOutF=%b want 0/0", Pcout, CarryOutF); end
        rst_n = 1'b1;
        model_clear();
        step();
        checks++; if (P !== 48'd0) begin errors++; $display("FAIL reset_first_edge_P got %h want 0", P); end
        checks++; if (M !== 36'd0) begin errors++; $display("FAIL reset_first_edge_M got %h want 0", M); end
        repeat (3) begin
            step();
            checks++;
            if (P !== 48'(ep[n]) || M !== 36'(em[n]) || Bcout !== 18'(eb1[n]))
                begin errors++; $display("FAIL refill got P=%h M=%h Bcout=%h want %h %h %h",
                                         P, M, Bcout, 48'(ep[n]), 36'(em[n]), 18'(eb1[n])); end
        end
    endtask

    task automatic test_preadd_mac();
        do_reset();
        A = 18'd9; B = 18'd4; D = 18'd1; C = 48'd5; PCIN = 48'd0; OPMODE = 8'b00111101;
        repeat (4) begin
            step();
            checks++; if (P !== 48'(ep[n])) begin errors++; $display("FAIL mac_step_P got %h want %h", P, 48'(ep[n])); end
        end
        checks++; if (Bcout !== 18'd5) begin errors++; $display("FAIL mac_Bcout got %0d want 5", Bcout); end
        checks++; if (M !== 36'd45)    begin errors++; $display("FAIL mac_M got %0d want 45", M); end
        checks++; if (P !== 48'd51)    begin errors++; $display("FAIL mac_P got %0d want 51", P); end
        checks++; if (CarryOut !== 1'b0) begin errors++; $display("FAIL mac_CarryOut got %b want 0", CarryOut); end
    endtask

    task automatic test_sub_concat();
        do_reset();
        A = 18'd3; B = 18'd8; D = 18'd20; C = 48'd10; PCIN = 48'h00F0000F0000;
        OPMODE = 8'b11010111;
        repeat (4) begin
            step();
            checks++; if (P !== 48'(ep[n])) begin errors++; $display("FAIL sub_step_P got %h want %h", P, 48'(ep[n])); end
        end
        checks++; if (Bcout !== 18'd12) begin errors++; $display("FAIL sub_Bcout got %0d want 12", Bcout); end
        checks++; if (M !== 36'd36)     begin errors++; $display("FAIL sub_M got %0d want 36", M); end
        checks++; if (P !== 48'hFFB00002FFF4) begin errors++; $display("FAIL sub_P got %h want FFB00002FFF4", P); end
        checks++; if (CarryOut !== 1'b1 || CarryOutF !== 1'b1)
            begin errors++; $display("FAIL sub_CarryOut got %b/%b want 1/1", CarryOut, CarryOutF); end
    endtask

    task automatic test_zero_sub();
        do_reset();
        A = 18'($urandom()); B = 18'($urandom()); D = 18'($urandom());
        C = 48'({$urandom(), $urandom()}); OPMODE = 8'b10000000;
        repeat (4) step();
        checks++; if (P !== 48'd0) begin errors++; $display("FAIL zero_sub_P got %h want 0", P); end
        checks++; if (CarryOut !== 1'b0) begin errors++; $display("FAIL zero_sub_CarryOut got %b want 0", CarryOut); end
    endtask

    task automatic test_accumulate();
        longint acc;
        do_reset();
        A = 18'd0; B = 18'd0; D = 18'd0; C = 48'd51; PCIN = 48'd0; OPMODE = 8'b00001100;
        repeat (3) step();
        checks++; if (P !== 48'd51) begin errors++; $display("FAIL acc_seed got %0d want 51", P); end
        OPMODE = 8'b01001010;
        step();  // OPMODE register loads; P still computed from C
        acc = 51;
        for (int i = 0; i < 48; i++) begin
            step();
            acc = (acc * 2) & c_mask48;
            checks++;
            if (P !== 48'(acc)) begin errors++; $display("FAIL acc_double[%0d] got %h want %h", i, P, 48'(acc)); end
        end
        CEP = 1'b0;
        step();
        checks++; if (P !== 48'(acc)) begin errors++; $display("FAIL acc_cep_hold got %h want %h", P, 48'(acc)); end
        CEP = 1'b1;
        acc = 48'd7;
        C = 48'd7; OPMODE = 8'b00001100;
        repeat (3) step();
        checks++; if (P !== 48'd7) begin errors++; $display("FAIL acc_reseed got %0d want 7", P); end
    endtask

    task automatic test_rstp_async();
        do_reset();
        A = 18'd9; B = 18'd4; D = 18'd1; C = 48'd5; PCIN = 48'd0; OPMODE = 8'b00111101;
        repeat (4) step();
        RSTP = 1'b1;
        step();
        checks++; if (P !== 48'd0) begin errors++; $display("FAIL rstp_clear got %0d want 0", P); end
        RSTP = 1'b0;
        step();
        checks++; if (P !== 48'd51) begin errors++; $display("FAIL rstp_reload got %0d want 51", P); end
        // asynchronous reset between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (P !== 48'd0 || M !== 36'd0 || Bcout !== 18'd0 || CarryOut !== 1'b0)
            begin errors++; $display("FAIL async_reset got P=%h M=%h Bcout=%h CO=%b want zeros", P, M, Bcout, CarryOut); end
        do_reset();
        repeat (3) step();
        checks++; if (P !== 48'(ep[n])) begin errors++; $display("FAIL async_refill_partial got %h want %h", P, 48'(ep[n])); end
        step();
        checks++; if (P !== 48'd51) begin errors++; $display("FAIL async_refill got %0d want 51", P); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            A = 18'($urandom()); B = 18'($urandom()); D = 18'($urandom());
            Bcin = 18'($urandom()); carryIn = 1'($urandom());
            C = 48'({$urandom(), $urandom()}); PCIN = 48'({$urandom(), $urandom()});
            OPMODE = 8'($urandom());
            RSTP = ($urandom_range(0, 15) == 0);
            CEP  = ($urandom_range(0, 7) != 0);
            step();
            checks++;
            if (P !== 48'(ep[n]) || Pcout !== 48'(ep[n]))
                begin errors++; $display("FAIL rand_P[%0d] got %h/%h want %h", i, P, Pcout, 48'(ep[n])); end
            checks++;
            if (M !== 36'(em[n]))
                begin errors++; $display("FAIL rand_M[%0d] got %h want %h", i, M, 36'(em[n])); end
            checks++;
            if (Bcout !== 18'(eb1[n]))
                begin errors++; $display("FAIL rand_Bcout[%0d] got %h want %h", i, Bcout, 18'(eb1[n])); end
            checks++;
            if (CarryOut !== 1'(ecyo[n]) || CarryOutF !== 1'(ecyo[n]))
                begin errors++; $display("FAIL rand_CarryOut[%0d] got %b/%b want %0d", i, CarryOut, CarryOutF, ecyo[n]); end
        end
        RSTP = 1'b0; CEP = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        A = '0; B = '0; Bcin = '0; D = '0; C = '0; PCIN = '0; carryIn = 1'b0; OPMODE = '0;
        RSTA = 1'b0; RSTB = 1'b0; RSTC = 1'b0; RSTD = 1'b0;
        RSTM = 1'b0; RSTP = 1'b0; RSTCarryIn = 1'b0; RST_OPMODE = 1'b0;
        CEA = 1'b1; CEB = 1'b1; CEC = 1'b1; CED = 1'b1;
        CEM = 1'b1; CEP = 1'b1; CECarryIn = 1'b1; CE_OPMODE = 1'b1;
        model_clear();
        #2;
        test_reset();
        test_preadd_mac();
        test_sub_concat();
        test_zero_sub();
        test_accumulate();
        test_rstp_async();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
